// File: rtl/ucie_ctl_sb_pkg.sv
// ucie_ctl_sb_pkg: shared state encoding, sizes and header bit layout for the sideband transmit path
package ucie_ctl_sb_pkg;

    typedef enum logic [2:0] {
        SB_IDLE,
        SB_HDR,
        SB_GAP1,
        SB_DATA,
        SB_GAP2
    } sb_state_e;

    localparam int SB_WORD_W = 64;
    localparam int SB_GAP_UI = 32;
    localparam int DP_BIT    = 63;
    localparam int CP_BIT    = 62;

    function automatic logic [SB_WORD_W-1:0] sb_build_hdr(
        input logic        dp,
        input logic        cp,
        input logic [29:0] phase1,
        input logic [31:0] phase0
    );
        logic [SB_WORD_W-1:0] h;
        h         = {2'b00, phase1, phase0};
        h[DP_BIT] = dp;
        h[CP_BIT] = cp;
        return h;
    endfunction

endpackage

// File: rtl/ucie_ctl_sb_piso.sv
// ucie_ctl_sb_piso: parallel-load, right-shifting register; serial_out is bit 0
// Ports: clk, rst (sync, active-high), load (priority over shift_en), shift_en,
//        load_data[W-1:0], serial_out.
module ucie_ctl_sb_piso #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] load_data,
    output logic         serial_out
);

    logic [W-1:0] q;

    always_ff @(posedge clk)
        q <= rst ? '0 : load ? load_data : shift_en ? {1'b0, q[W-1:1]} : q;

    assign serial_out = q[0];

endmodule

// File: rtl/ucie_ctl_sb_tx_serializer.sv
// ucie_ctl_sb_tx_serializer: sideband framer, serializes header then optional payload LSB first with zero gaps
// Ports: i_clk, i_rst (sync, active-high); i_valid/o_ready handshake; i_concat_phase0..3,
//        i_cp, i_dp, i_has_data captured on accept; o_sb_data serial bit; o_busy; o_pkt_done pulse.
// Optional: UCIE_CTL_SB_TX_CLK_STROBE_EN adds o_sb_clk_en, high while a word bit is on o_sb_data.
module ucie_ctl_sb_tx_serializer
    import ucie_ctl_sb_pkg::*;
#(
    parameter int WORD_W = SB_WORD_W,
    parameter int GAP_UI = SB_GAP_UI
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_concat_phase0,
    input  logic [29:0] i_concat_phase1,
    input  logic [31:0] i_concat_phase2,
    input  logic [31:0] i_concat_phase3,
    input  logic        i_cp,
    input  logic        i_dp,
    input  logic        i_has_data,
    output logic        o_sb_data,
    output logic        o_busy,
`ifdef UCIE_CTL_SB_TX_CLK_STROBE_EN
    output logic        o_sb_clk_en,
`endif
    output logic        o_pkt_done
);

    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] WORD_LAST = CW'(WORD_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_UI - 1);

    sb_state_e         state;
    logic [CW-1:0]     cnt;
    logic [WORD_W-1:0] hdr, pld_q, load_data;
    logic              has_data_q, accept, piso_load, piso_shift, piso_out;

    assign hdr = sb_build_hdr(i_dp, i_cp, i_concat_phase1, i_concat_phase0);

    // Bit 0 of each word goes straight to o_sb_data on entry, so the PISO is kept one
    // bit ahead: header is loaded pre-shifted, payload is shifted on GAP1->DATA.
    always_comb begin
        accept     = o_ready && i_valid;
        piso_load  = accept || (state == SB_HDR && cnt == WORD_LAST);
        piso_shift = state == SB_HDR || state == SB_DATA || (state == SB_GAP1 && cnt == GAP_LAST);
        load_data  = accept ? hdr >> 1 : pld_q;
    end

    ucie_ctl_sb_piso #(.W(WORD_W)) u_piso (
        .clk       (i_clk),
        .rst       (i_rst),
        .load      (piso_load),
        .shift_en  (piso_shift),
        .load_data (load_data),
        .serial_out(piso_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= SB_IDLE;
            cnt        <= '0;
            pld_q      <= '0;
            has_data_q <= 1'b0;
            o_sb_data  <= 1'b0;
            o_busy     <= 1'b0;
            o_ready    <= 1'b1;
            o_pkt_done <= 1'b0;
`ifdef UCIE_CTL_SB_TX_CLK_STROBE_EN
            o_sb_clk_en <= 1'b0;
`endif
        end else begin
            o_sb_data  <= 1'b0;
            o_pkt_done <= 1'b0;
`ifdef UCIE_CTL_SB_TX_CLK_STROBE_EN
            o_sb_clk_en <= 1'b0;
`endif
            case (state)
                SB_IDLE: if (accept) begin
                    state      <= SB_HDR;
                    cnt        <= '0;
                    pld_q      <= {i_concat_phase3, i_concat_phase2};
                    has_data_q <= i_has_data;
                    o_sb_data  <= hdr[0];
                    o_busy     <= 1'b1;
                    o_ready    <= 1'b0;
`ifdef UCIE_CTL_SB_TX_CLK_STROBE_EN
                    o_sb_clk_en <= 1'b1;
`endif
                end
                SB_HDR, SB_DATA: if (cnt == WORD_LAST) begin
                    state <= state == SB_HDR ? SB_GAP1 : SB_GAP2;
                    cnt   <= '0;
                end else begin
                    cnt       <= cnt + 1'b1;
                    o_sb_data <= piso_out;
`ifdef UCIE_CTL_SB_TX_CLK_STROBE_EN
                    o_sb_clk_en <= 1'b1;
`endif
                end
                SB_GAP1, SB_GAP2: if (cnt == GAP_LAST) begin
                    cnt <= '0;
                    if (state == SB_GAP1 && has_data_q) begin
                        state     <= SB_DATA;
                        o_sb_data <= piso_out;
`ifdef UCIE_CTL_SB_TX_CLK_STROBE_EN
                        o_sb_clk_en <= 1'b1;
`endif
                    end else begin
                        state   <= SB_IDLE;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end else begin
                    cnt        <= cnt + 1'b1;
                    o_pkt_done <= cnt == GAP_LAST - 1'b1 && (state == SB_GAP2 || !has_data_q);
                end
                default: state <= SB_IDLE;
            endcase
        end
    end

endmodule
